if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch front end that sits directly upstream of the pipelined CPU core. It owns the PC, issues word fetches to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small queue. It presents one instruction per cycle to the IF/ID boundary and applies branch/jump redirects, discarding wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
QDEPTH, 2, instruction queue entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  fetch request valid
imem_addr  out  32  word address of the pending fetch; bits[1:0] always 0
imem_ack  in  1  memory accepts req and returns data this cycle
imem_rdata  in  32  instruction word, valid when imem_req && imem_ack
redirect  in  1  branch/jump taken; flush and refetch
redirect_pc  in  32  new PC; bits[1:0] ignored (forced 0)
stall  in  1  downstream IF/ID not accepting this cycle
instr_valid  out  1  instr/instr_pc hold a valid instruction
instr  out  32  head instruction word
instr_pc  out  32  PC of head instruction
pc_plus4  out  32  instr_pc + 4 (mod 2^32)

Behaviour:
- Reset (async, rst_n low): queue empty, instr_valid=0, imem_req=0, fetch_pc=RESET_PC, state=RUN, imem_addr=RESET_PC. First imem_req on the first clock edge after rst_n rises.
- Reset mid-handshake: imem_req drops immediately; the in-flight fetch is abandoned; restarts at RESET_PC.
- FSM states: RUN, DRAIN.
- RUN: imem_req = (count < QDEPTH), from registered state only. imem_addr = fetch_pc.
- Handshake: transfer when imem_req && imem_ack. Once raised, imem_req and imem_addr stay stable until ack, or until a redirect moves the block to DRAIN, where they are still held.
- Transfer in RUN: push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0.
- Push never overflows, because only one transfer per cycle is possible and it requires count < QDEPTH.
- Consume: pop when instr_valid && !stall. Push and pop in the same cycle leave count unchanged.
- Latency: ack at edge t -> instr_valid at t+1. With a zero-wait memory (ack=1) and stall=0, throughput is 1 instruction/cycle.
- Outputs: instr_valid = (count != 0). instr, instr_pc, pc_plus4 come from the queue head and are don't-care when invalid. Head stays stable while stalled.
- Redirect (priority over stall, pop and push):
  - Queue flushed (count=0); any push this cycle is discarded.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - If imem_req=1 and imem_ack=0 this cycle, go to DRAIN.
  - Otherwise stay in RUN; next cycle imem_req=1 at the new PC.
- DRAIN:
  - imem_req=1, imem_addr holds the old issued address.
  - On ack, data is discarded and the block returns to RUN; a request for fetch_pc is issued the following cycle.
  - instr_valid=0 throughout DRAIN.
  - A further redirect in DRAIN updates fetch_pc and stays in DRAIN.
- Redirect coincident with ack in RUN: returned word is dropped; next cycle requests redirect_pc.
- stall with an empty queue has no effect.

Decomposition:
- Shared package if_pkg:
  - typedef fetch_state_t {RUN, DRAIN}
  - struct fetch_entry_t {pc[31:0], instr[31:0]}
  - localparam PC_STEP=4
  - default RESET_PC constant
- One sub-module: if_fetch_queue, a synchronous QDEPTH-entry FIFO of fetch_entry_t with push, pop, flush, count, head outputs. Flush has priority over push.
- FSM, PC and handshake logic stay in if_fetch_stage.

Test Plan:
1. Zero-wait ack=1, stall=0, after reset -> imem_addr 0,4,8,…; instr_valid from 2nd cycle after reset release; instr_pc sequence 0,4,8; pc_plus4 = instr_pc+4.
2. stall=1 for 5 cycles with ack=1 -> queue fills to 2; imem_req drops; instr/instr_pc frozen. Release stall -> no lost or duplicated PCs; fetch resumes at head_pc+8.
3. Memory with 3-cycle ack latency, redirect to 0x100 on req cycle 1 -> DRAIN; imem_addr unchanged until ack; returned word dropped; next request 0x100; first valid instr_pc=0x100.
4. Redirect to 0x203 in the same cycle as ack -> returned word never becomes valid; next imem_addr=0x200.
5. Redirect to 0xFFFF_FFF8, ack=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0x0; pc_plus4 for 0xFFFF_FFFC = 0x0.
6. rst_n low while imem_req high and no ack -> imem_req=0 and instr_valid=0 immediately; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Instruction fetches are always word aligned.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Small FIFO holding fetched instructions with their PCs; flush wins over push.
module if_fetch_queue
   import if_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  fetch_entry_t              push_entry,
   output logic [$clog2(QDEPTH):0]   count,
   output fetch_entry_t              head
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   fetch_entry_t   mem [QDEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   // Qualify push/pop: a flush cancels both, and popping an empty queue is ignored.
   always_comb begin
      do_push = push && !flush;
      do_pop  = pop && (count != '0) && !flush;
   end

   // Entry storage needs no reset; entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch front end: owns the PC, runs the imem req/ack handshake and handles redirects.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4
);

   localparam int          AW       = $clog2(QDEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(QDEPTH);

   fetch_state_t  state;
   fetch_state_t  state_next;
   logic [31:0]   fetch_pc;
   logic [31:0]   fetch_pc_next;
   logic [31:0]   drain_addr;
   logic [31:0]   drain_addr_next;
   logic          fetch_en;
   logic [AW:0]   count;
   logic          push;
   logic          pop;
   fetch_entry_t  push_entry;
   fetch_entry_t  head;

   // Request and address come only from registered state so they stay stable until ack.
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc;
      if (state == DRAIN) begin
         imem_req  = 1'b1;
         imem_addr = drain_addr;
      end else begin
         imem_req  = fetch_en && (count < FULL_CNT);
      end
   end

   // Next-state, PC update, queue push/pop; redirect overrides everything else.
   always_comb begin
      state_next       = state;
      fetch_pc_next    = fetch_pc;
      drain_addr_next  = drain_addr;
      push             = 1'b0;
      pop              = instr_valid && !stall;
      push_entry.pc    = fetch_pc;
      push_entry.instr = imem_rdata;
      case (state)
         RUN: begin
            if (redirect) begin
               fetch_pc_next = word_align(redirect_pc);
               if (imem_req && !imem_ack) begin
                  state_next      = DRAIN;
                  drain_addr_next = fetch_pc;
               end
            end else if (imem_req && imem_ack) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + PC_STEP;
            end
         end
         DRAIN: begin
            if (redirect) begin
               fetch_pc_next = word_align(redirect_pc);
            end
            if (imem_ack) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   // State registers; fetch_en delays the first request to the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         fetch_pc   <= word_align(RESET_PC);
         drain_addr <= word_align(RESET_PC);
         fetch_en   <= 1'b0;
      end else begin
         state      <= state_next;
         fetch_pc   <= fetch_pc_next;
         drain_addr <= drain_addr_next;
         fetch_en   <= 1'b1;
      end
   end

   if_fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .pop        (pop),
      .flush      (redirect),
      .push_entry (push_entry),
      .count      (count),
      .head       (head)
   );

   assign instr_valid = (count != '0);
   assign instr       = head.instr;
   assign instr_pc    = head.pc;
   assign pc_plus4    = head.pc + PC_STEP;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed scenarios followed by a random run.
module tb_if_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   int          compared = 0;
   int          mismatched = 0;
   int          consumed = 0;
   int          idle_run = 0;
   bit          prev_pending = 0;
   logic [31:0] prev_addr = '0;

   if_fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .QDEPTH   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .stall       (stall),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .pc_plus4    (pc_plus4)
   );

   // Instruction memory contents: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference program stream: sequential words starting at the last redirect/reset target.
   task automatic refillModel();
      exp_t e;
      while (exp_q.size() < 8) begin
         e.pc    = gen_pc;
         e.instr = mem_word(gen_pc);
         exp_q.push_back(e);
         gen_pc  = gen_pc + 32'd4;
      end
   endtask

   task automatic restartModel(input logic [31:0] pc);
      exp_q.delete();
      gen_pc = {pc[31:2], 2'b00};
      refillModel();
   endtask

   task automatic applyStimulus(input logic st, input logic ak, input logic rd, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      stall       = st;
      imem_ack    = ak;
      redirect    = rd;
      redirect_pc = rpc;
      if (rd && rst_n) begin
         restartModel(rpc);
      end
   endtask

   task automatic doReset(input logic ak);
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      redirect = 1'b0;
      stall    = 1'b0;
      imem_ack = ak;
      restartModel(32'h0000_0000);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   // Monitor: compares the presented head with the scoreboard and pops on each consume.
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("reset_req", {31'd0, imem_req}, 32'd0);
         checkOutput("reset_valid", {31'd0, instr_valid}, 32'd0);
         prev_pending = 1'b0;
         idle_run     = 0;
      end else begin
         if (prev_pending) begin
            checkOutput("req_held", {31'd0, imem_req}, 32'd1);
            checkOutput("addr_held", imem_addr, prev_addr);
         end
         if (imem_req) begin
            checkOutput("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
         end
         if (!imem_req && !instr_valid) idle_run++;
         else idle_run = 0;
         checkOutput("no_deadlock", {31'd0, idle_run > 2}, 32'd0);
         if (instr_valid && !redirect) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL head_pc: got %h, expected no valid instruction", instr_pc);
            end else begin
               checkOutput("head_pc", instr_pc, exp_q[0].pc);
               checkOutput("head_instr", instr, exp_q[0].instr);
               checkOutput("pc_plus4", pc_plus4, exp_q[0].pc + 32'd4);
               if (!stall) begin
                  void'(exp_q.pop_front());
                  consumed++;
                  refillModel();
               end
            end
         end
         prev_pending = imem_req && !imem_ack;
         prev_addr    = imem_addr;
      end
   end

   // Directed scenarios, then randomized traffic.
   initial begin
      logic [31:0] p;
      logic st, ak, rd;
      logic [31:0] rpc;
      int ack_pct;

      rst_n       = 1'b0;
      imem_ack    = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      stall       = 1'b0;
      restartModel(32'h0000_0000);

      // Zero-wait memory from reset.
      doReset(1'b1);
      checkOutput("t1_req_before_edge", {31'd0, imem_req}, 32'd0);
      checkOutput("t1_valid_before_edge", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_first_req", {31'd0, imem_req}, 32'd1);
      checkOutput("t1_first_addr", imem_addr, 32'h0);
      checkOutput("t1_not_yet_valid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("t1_pc0", instr_pc, 32'h0);
      checkOutput("t1_plus4_0", pc_plus4, 32'h4);
      checkOutput("t1_addr4", imem_addr, 32'h4);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_pc4", instr_pc, 32'h4);
      checkOutput("t1_addr8", imem_addr, 32'h8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t1_pc8", instr_pc, 32'h8);

      // Stall with a full queue, then release.
      p = '0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
         if (i == 0) begin
            p = exp_q[0].pc;
         end else begin
            checkOutput("t2_req_dropped", {31'd0, imem_req}, 32'd0);
            checkOutput("t2_addr_next", imem_addr, p + 32'd8);
            checkOutput("t2_head_frozen", instr_pc, p);
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t2_resume_req", {31'd0, imem_req}, 32'd1);
      checkOutput("t2_resume_addr", imem_addr, p + 32'd8);
      checkOutput("t2_next_head", instr_pc, p + 32'd4);

      // Slow memory with a redirect while the request is outstanding.
      doReset(1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
      checkOutput("t3_req_cycle1", {31'd0, imem_req}, 32'd1);
      checkOutput("t3_addr_cycle1", imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("t3_drain_req", {31'd0, imem_req}, 32'd1);
      checkOutput("t3_drain_addr", imem_addr, 32'h0);
      checkOutput("t3_drain_invalid", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_drain_addr_ack", imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_new_addr", imem_addr, 32'h100);
      checkOutput("t3_dropped_word", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t3_first_valid", {31'd0, instr_valid}, 32'd1);
      checkOutput("t3_first_pc", instr_pc, 32'h100);

      // Redirect coinciding with an ack.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0203);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t4_addr", imem_addr, 32'h200);
      checkOutput("t4_flushed", {31'd0, instr_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t4_pc", instr_pc, 32'h200);

      // PC wrap at the top of the address space.
      applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_addr_fff8", imem_addr, 32'hFFFF_FFF8);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_pc_fff8", instr_pc, 32'hFFFF_FFF8);
      checkOutput("t5_addr_fffc", imem_addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_pc_fffc", instr_pc, 32'hFFFF_FFFC);
      checkOutput("t5_plus4_wrap", pc_plus4, 32'h0);
      checkOutput("t5_addr_wrap", imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t5_pc_wrap", instr_pc, 32'h0);

      // Reset asserted while a request is waiting for ack.
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("t6_req_pending", {31'd0, imem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_req_async", {31'd0, imem_req}, 32'd0);
      checkOutput("t6_valid_async", {31'd0, instr_valid}, 32'd0);
      restartModel(32'h0000_0000);
      repeat (2) @(posedge clk);
      #3;
      imem_ack = 1'b1;
      rst_n    = 1'b1;
      #1;
      checkOutput("t6_req_after_release", {31'd0, imem_req}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("t6_restart_req", {31'd0, imem_req}, 32'd1);
      checkOutput("t6_restart_addr", imem_addr, 32'h0);

      // Random traffic with varying memory speed, stalls, redirects and resets.
      consumed = 0;
      for (int i = 0; i < 3000; i++) begin
         ack_pct = 30 + 20 * ((i / 500) % 4);
         st = ($urandom_range(0, 99) < 30);
         ak = ($urandom_range(0, 99) < ack_pct);
         rd = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = $urandom;
            1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: rpc = 32'($urandom_range(0, 1023));
         endcase
         applyStimulus(st, ak, rd, rpc);
         if ($urandom_range(0, 399) == 0) begin
            #1;
            rst_n = 1'b0;
            restartModel(32'h0000_0000);
            repeat (2) @(posedge clk);
            #3;
            rst_n = 1'b1;
         end
      end
      checkOutput("random_progress", {31'd0, consumed >= 300}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
